// File: rtl/decode_pipe.sv
// Decode stage: register file, per-register pending-write scoreboard and ID/EX register with valid/ready.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data to source operands.
module decode_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int CTRL_W = 16,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic [DATA_W-1:0] out_imm,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              err
);
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0]   rf_reg   [NUM_REGS];
    logic [PEND_W-1:0]   cnt_reg  [NUM_REGS];
    logic [PEND_W-1:0]   cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] wb_hit;
    logic [NUM_REGS-1:0] kill_hit;
    logic [NUM_REGS-1:0] inc_hit;
    logic [NUM_REGS-1:0] empty_after_kill;
    logic                hazard;
    logic                fire;
    logic                kill;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;

    assign kill     = flush & out_valid & out_rd_we;
    assign hazard   = (in_use_rs & busy[in_rs]) | (in_use_rt & busy[in_rt])
                    | (in_rd_we & (cnt_reg[in_rd] == CNT_MAX));
    assign in_ready = rst & ~flush & ~hazard & (~out_valid | out_ready);
    assign fire     = in_valid & in_ready;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [PEND_W-1:0] cnt_after_kill;
            assign wb_hit[gi]           = wb_we & (wb_sel == REG_AW'(gi));
            assign kill_hit[gi]         = kill & (out_rd == REG_AW'(gi));
            assign inc_hit[gi]          = fire & in_rd_we & (in_rd == REG_AW'(gi));
            assign cnt_after_kill       = cnt_reg[gi] - PEND_W'(kill_hit[gi]);
            assign empty_after_kill[gi] = (cnt_after_kill == '0);
            // A writeback against an empty counter leaves it at zero instead of wrapping.
            assign cnt_next[gi] = cnt_after_kill - PEND_W'(wb_hit[gi] & ~empty_after_kill[gi])
                                + PEND_W'(inc_hit[gi]);
`ifdef DECODE_BYPASS_EN
            assign busy[gi] = cnt_reg[gi] > PEND_W'(wb_hit[gi]);
`else
            assign busy[gi] = (cnt_reg[gi] != '0);
`endif
        end
    endgenerate

    always_comb begin
        rs_data = rf_reg[in_rs];
        rt_data = rf_reg[in_rt];
`ifdef DECODE_BYPASS_EN
        if (wb_we && (wb_sel == in_rs)) rs_data = wb_data;
        if (wb_we && (wb_sel == in_rt)) rt_data = wb_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_reg[i]  <= '0;
                cnt_reg[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_reg[i] <= cnt_next[i];
                if (wb_hit[i]) rf_reg[i] <= wb_data;
            end
            if (|(wb_hit & empty_after_kill)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_rs_data <= '0;
            out_rt_data <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_imm     <= '0;
            out_ctrl    <= '0;
        end else if (fire) begin
            out_valid   <= 1'b1;
            out_rs_data <= rs_data;
            out_rt_data <= rt_data;
            out_rd      <= in_rd;
            out_rd_we   <= in_rd_we;
            out_imm     <= in_imm;
            out_ctrl    <= in_ctrl;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed scenarios plus randomized traffic
// checked against a queue-free behavioural model of the scoreboard and register file.
module tb_decode_pipe;
    localparam int NREG     = 8;
    localparam int PEND_MAX = 3;

    logic        clk, rst, in_valid, in_ready, in_use_rs, in_use_rt, in_rd_we;
    logic        out_valid, out_ready, out_rd_we, wb_we, flush, err;
    logic [2:0]  in_rs, in_rt, in_rd, out_rd, wb_sel;
    logic [15:0] in_imm, in_ctrl, out_imm, out_ctrl, out_rs_data, out_rt_data, wb_data;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [15:0] m_rf [NREG];
    int          m_cnt [NREG];
    bit          m_ov, m_rdwe, m_err, last_rdy;
    logic [2:0]  m_rd;
    logic [15:0] m_rs, m_rt, m_imm, m_ctrl;

    decode_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_imm(in_imm), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_imm(out_imm), .out_ctrl(out_ctrl),
        .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_busy(input int r);
`ifdef DECODE_BYPASS_EN
        return m_cnt[r] > ((wb_we && int'(wb_sel) == r) ? 1 : 0);
`else
        return m_cnt[r] != 0;
`endif
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = (in_use_rs && m_busy(int'(in_rs))) || (in_use_rt && m_busy(int'(in_rt)))
           || (in_rd_we && m_cnt[in_rd] == PEND_MAX);
        return rst && !flush && !hz && (!m_ov || out_ready);
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit          fire;
        logic [15:0] rs_v, rt_v;
        @(posedge clk);
        last_rdy = m_ready();
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_rf[i]  = '0;
                m_cnt[i] = 0;
            end
            m_ov = 0; m_rdwe = 0; m_err = 0; m_rd = '0;
            m_rs = '0; m_rt = '0; m_imm = '0; m_ctrl = '0;
        end else begin
            fire = in_valid && last_rdy;
            rs_v = m_rf[in_rs];
            rt_v = m_rf[in_rt];
`ifdef DECODE_BYPASS_EN
            if (wb_we && wb_sel == in_rs) rs_v = wb_data;
            if (wb_we && wb_sel == in_rt) rt_v = wb_data;
`endif
            if (flush && m_ov && m_rdwe) m_cnt[m_rd] = m_cnt[m_rd] - 1;
            if (wb_we) begin
                if (m_cnt[wb_sel] == 0) m_err = 1;
                else m_cnt[wb_sel] = m_cnt[wb_sel] - 1;
                m_rf[wb_sel] = wb_data;
            end
            if (fire && in_rd_we) m_cnt[in_rd] = m_cnt[in_rd] + 1;
            if (fire) begin
                m_ov = 1; m_rs = rs_v; m_rt = rt_v; m_rd = in_rd;
                m_rdwe = in_rd_we; m_imm = in_imm; m_ctrl = in_ctrl;
            end else if (flush || out_ready) begin
                m_ov = 0;
            end
        end
        #2;
    endtask

    task automatic idle();
        in_valid = 0; in_rs = '0; in_rt = '0; in_use_rs = 0; in_use_rt = 0;
        in_rd = '0; in_rd_we = 0; in_imm = '0; in_ctrl = '0;
        out_ready = 1; wb_we = 0; wb_sel = '0; wb_data = '0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic set_instr(input logic [2:0] rs, input bit use_rs, input logic [2:0] rt,
                             input bit use_rt, input logic [2:0] rd, input bit rd_we,
                             input logic [15:0] imm, input logic [15:0] ctrl);
        in_valid = 1; in_rs = rs; in_use_rs = use_rs; in_rt = rt; in_use_rt = use_rt;
        in_rd = rd; in_rd_we = rd_we; in_imm = imm; in_ctrl = ctrl;
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        set_instr(3'd0, 0, 3'd0, 0, 3'd1, 1, 16'h1111, 16'h2222);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if ({out_rs_data, out_rt_data, out_imm, out_ctrl, out_rd, out_rd_we} !== 68'd0) begin
            errors++; $display("FAIL reset_out_data got %h %h %h %h %h %b want all 0",
                               out_rs_data, out_rt_data, out_imm, out_ctrl, out_rd, out_rd_we);
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1;
        in_valid = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_wb_read();
        logic [15:0] imm;
        do_reset();
        wb_we = 1; wb_sel = 3'd3; wb_data = 16'h1234;
        tick();
        wb_we = 0;
        imm = 16'($urandom);
        set_instr(3'd3, 1, 3'd0, 0, 3'd0, 0, imm, 16'h00A5);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wb_read_ready got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        $display("issue rs=3 imm=%h -> out_rs_data=%h", imm, out_rs_data);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL wb_read_valid got %b want 1", out_valid); end
        checks++; if (out_rs_data !== 16'h1234) begin errors++; $display("FAIL wb_read_data got %h want 1234", out_rs_data); end
        checks++; if (out_imm !== imm) begin errors++; $display("FAIL wb_read_imm got %h want %h", out_imm, imm); end
        // the writeback found no pending write, so the sticky error is raised
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL wb_read_err got %b want 1", err); end
    endtask

    task automatic test_hazard();
        logic [15:0] d;
        do_reset();
        set_instr(3'd0, 0, 3'd0, 0, 3'd2, 1, 16'h0001, 16'h0000);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_producer_ready got %b want 1", in_ready); end
        tick();
        set_instr(3'd0, 0, 3'd2, 1, 3'd0, 0, 16'h0002, 16'h0000);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall cycle %0d got %b want 0", i, in_ready); end
            tick();
        end
        d = 16'($urandom);
        wb_we = 1; wb_sel = 3'd2; wb_data = d;
        #1;
`ifdef DECODE_BYPASS_EN
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_bypass_ready got %b want 1", in_ready); end
        tick();
        wb_we = 0; in_valid = 0;
`else
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_wb_cycle_ready got %b want 0", in_ready); end
        tick();
        wb_we = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_after_wb_ready got %b want 1", in_ready); end
        tick();
        in_valid = 0;
`endif
        $display("issue rt=2 after wb data=%h -> out_rt_data=%h", d, out_rt_data);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hazard_valid got %b want 1", out_valid); end
        checks++; if (out_rt_data !== d) begin errors++; $display("FAIL hazard_rt_data got %h want %h", out_rt_data, d); end
    endtask

    task automatic test_pend_max();
        do_reset();
        set_instr(3'd0, 0, 3'd0, 0, 3'd5, 1, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            in_imm = 16'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pend_issue %0d got %b want 1", i, in_ready); end
            tick();
        end
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pend_full got %b want 0", in_ready); end
        tick();
        wb_we = 1; wb_sel = 3'd5; wb_data = 16'h5555;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pend_full_wb_cycle got %b want 0", in_ready); end
        tick();
        wb_we = 0;
        in_imm = 16'h0BEE;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pend_release got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 16'h0BEE || out_rd !== 3'd5) begin
            errors++; $display("FAIL pend_fourth_issue got v=%b imm=%h rd=%0d want v=1 imm=0bee rd=5",
                               out_valid, out_imm, out_rd);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b;
        do_reset();
        out_ready = 0;
        a = 16'($urandom);
        b = ~a;
        set_instr(3'd1, 0, 3'd1, 0, 3'd1, 0, a, a ^ 16'h0F0F);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
        tick();
        in_imm = b; in_ctrl = b ^ 16'h0F0F;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked_ready got %b want 0", in_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_imm !== a || out_ctrl !== (a ^ 16'h0F0F)) begin
                errors++; $display("FAIL bp_hold cycle %0d got v=%b imm=%h ctrl=%h want v=1 imm=%h ctrl=%h",
                                   i, out_valid, out_imm, out_ctrl, a, a ^ 16'h0F0F);
            end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_imm !== b) begin
            errors++; $display("FAIL bp_second_load got v=%b imm=%h want v=1 imm=%h", out_valid, out_imm, b);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush_err();
        do_reset();
        out_ready = 0;
        set_instr(3'd0, 0, 3'd0, 0, 3'd4, 1, 16'h4444, 16'h0000);
        tick();
        in_valid = 0;
        flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_refuse got %b want 0", in_ready); end
        tick();
        flush = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got %b want 0", out_valid); end
        set_instr(3'd4, 1, 3'd0, 0, 3'd0, 0, 16'h0004, 16'h0000);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_cnt_restored got %b want 1", in_ready); end
        tick();
        in_valid = 0; out_ready = 1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err_clear got %b want 0", err); end
        wb_we = 1; wb_sel = 3'd4; wb_data = 16'hDEAD;
        tick();
        wb_we = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL flush_err_set got %b want 1", err); end
        repeat (3) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL flush_err_sticky got %b want 1", err); end
        rst = 0;
        tick();
        rst = 1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err_reset got %b want 0", err); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 0;
        set_instr(3'd0, 0, 3'd0, 0, 3'd6, 1, 16'h6666, 16'h7777);
        tick();
        rst = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", in_ready); end
        tick();
        checks++;
        if ({out_valid, out_rs_data, out_rt_data, out_imm, out_ctrl, out_rd, out_rd_we, err} !== 70'd0) begin
            errors++; $display("FAIL midrst_outputs got v=%b imm=%h ctrl=%h rd=%0d we=%b err=%b want all 0",
                               out_valid, out_imm, out_ctrl, out_rd, out_rd_we, err);
        end
        rst = 1;
        set_instr(3'd6, 1, 3'd6, 1, 3'd6, 1, 16'h0006, 16'h0000);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_cnt_cleared got %b want 1", in_ready); end
        tick();
        in_valid = 0;
    endtask

    task automatic test_random();
        int r, eff;
        bit exp_rdy;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (!(in_valid && !last_rdy)) begin
                set_instr(3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                          16'($urandom), 16'($urandom));
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            wb_we = 0;
            r = $urandom_range(0, 7);
            eff = m_cnt[r] - ((flush && m_ov && m_rdwe && int'(m_rd) == r) ? 1 : 0);
            if (eff > 0 && $urandom_range(0, 1) == 1) begin
                wb_we = 1; wb_sel = 3'(r); wb_data = 16'($urandom);
            end
            #1;
            exp_rdy = m_ready();
            checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready n=%0d got %b want %b", n, in_ready, exp_rdy); end
            if (in_valid && exp_rdy)
                $display("issue n=%0d rs=%0d rt=%0d rd=%0d we=%b imm=%h", n, in_rs, in_rt, in_rd, in_rd_we, in_imm);
            tick();
            checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, out_valid, m_ov); end
            checks++;
            if (out_rs_data !== m_rs || out_rt_data !== m_rt) begin
                errors++; $display("FAIL rnd_operands n=%0d got %h %h want %h %h", n, out_rs_data, out_rt_data, m_rs, m_rt);
            end
            checks++;
            if (out_rd !== m_rd || out_rd_we !== m_rdwe || out_imm !== m_imm || out_ctrl !== m_ctrl) begin
                errors++; $display("FAIL rnd_fields n=%0d got %0d %b %h %h want %0d %b %h %h", n,
                                   out_rd, out_rd_we, out_imm, out_ctrl, m_rd, m_rdwe, m_imm, m_ctrl);
            end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %b want %b", n, err, m_err); end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 0;
        last_rdy = 0;
        test_reset();
        test_wb_read();
        test_hazard();
        test_pend_max();
        test_backpressure();
        test_flush_err();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
